// File: rtl/mem_access_sequencer_if.sv
// CPU-side request/response bundle for mem_access_sequencer.
// The CPU drives requests through the master modport; the sequencer answers through the slave modport.
interface mem_access_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences one CPU load/store at a time onto a single-cycle Memory port.
// Define MEM_ACCESS_MISALIGN_SPLIT_EN to split misaligned accesses into byte accesses; otherwise they are rejected.
module mem_access_sequencer (
  input  logic                         clk,
  input  logic                         rst,
  mem_access_sequencer_if.slave        cpu,
  output logic [31:0]                  address,
  output logic [31:0]                  data,
  output logic [2:0]                   writeMode,
  output logic [2:0]                   readMode,
  output logic                         unsignedLoad,
  input  logic [31:0]                  dataOutput
);

  localparam logic [2:0] MODE_NONE     = 3'd0;
  localparam logic [2:0] MODE_BYTE     = 3'd1;
  localparam logic [2:0] MODE_HALFWORD = 3'd2;
  localparam logic [2:0] MODE_WORD     = 3'd3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  localparam logic [1:0] SPLIT  = 2'd2;
`endif
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic        isWrite;
  logic [1:0]  sizeR;
  logic        isUnsigned;
  logic [31:0] addrR;
  logic [31:0] wdataR;
  logic [31:0] rdataR;
  logic        errR;
  logic        misaligned;
  logic        rejectReq;

  function automatic logic [2:0] sizeToMode(input logic [1:0] size);
    case (size)
      2'd0:    return MODE_BYTE;
      2'd1:    return MODE_HALFWORD;
      2'd2:    return MODE_WORD;
      default: return MODE_NONE;
    endcase
  endfunction

  assign misaligned = (cpu.req_size == 2'd1 && cpu.req_addr[0]) ||
                      (cpu.req_size == 2'd2 && cpu.req_addr[1:0] != 2'b00);

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  assign rejectReq = (cpu.req_size == 2'd3);

  logic [1:0]  byteIdx;
  logic [31:0] accR;
  logic [31:0] splitAcc;
  logic [31:0] splitResult;
  logic        splitLast;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    splitAcc = accR;
    splitAcc[{byteIdx, 3'b000} +: 8] = dataOutput[7:0];
    splitLast = (byteIdx == ((sizeR == 2'd1) ? 2'd1 : 2'd3));
    if (isWrite)
      splitResult = 32'd0;
    else if (sizeR == 2'd1 && !isUnsigned)
      splitResult = {{16{splitAcc[15]}}, splitAcc[15:0]};
    else
      splitResult = splitAcc;
  end
`else
  assign rejectReq = (cpu.req_size == 2'd3) || misaligned;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      isWrite    <= 1'b0;
      sizeR      <= 2'd0;
      isUnsigned <= 1'b0;
      addrR      <= 32'd0;
      wdataR     <= 32'd0;
      rdataR     <= 32'd0;
      errR       <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
      byteIdx    <= 2'd0;
      accR       <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req_valid) begin
            isWrite    <= cpu.req_write;
            sizeR      <= cpu.req_size;
            isUnsigned <= cpu.req_unsigned;
            addrR      <= cpu.req_addr;
            wdataR     <= cpu.req_wdata;
            errR       <= rejectReq;
            if (rejectReq) begin
              rdataR <= 32'd0;
              state  <= RESP;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
            end else if (misaligned) begin
              byteIdx <= 2'd0;
              accR    <= 32'd0;
              state   <= SPLIT;
`endif
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rdataR <= isWrite ? 32'd0 : dataOutput;
          state  <= RESP;
        end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
        SPLIT: begin
          accR    <= splitAcc;
          byteIdx <= byteIdx + 2'd1;
          if (splitLast) begin
            rdataR <= splitResult;
            state  <= RESP;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.req_ready = (state == IDLE);
  assign cpu.rsp_valid = (state == RESP);
  assign cpu.rsp_err   = errR && (state == RESP);
  assign cpu.rsp_rdata = rdataR;

  always_comb begin
    address      = 32'd0;
    data         = 32'd0;
    writeMode    = MODE_NONE;
    readMode     = MODE_NONE;
    unsignedLoad = 1'b0;
    if (state == ACCESS) begin
      address = addrR;
      if (isWrite) begin
        writeMode = sizeToMode(sizeR);
        data      = wdataR;
      end else begin
        readMode     = sizeToMode(sizeR);
        unsignedLoad = isUnsigned;
      end
    end
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    if (state == SPLIT) begin
      // Byte k of the request lives at addrR+k; the sum wraps naturally at 2^32.
      address = addrR + {30'd0, byteIdx};
      if (isWrite) begin
        writeMode = MODE_BYTE;
        data      = {24'd0, wdataR[{byteIdx, 3'b000} +: 8]};
      end else begin
        readMode     = MODE_BYTE;
        unsignedLoad = 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer with a little-endian byte memory model.
// Covers the MEM_ACCESS_MISALIGN_SPLIT_EN build and the default build.
module tb_mem_access_sequencer;

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_BYTE = 3'd1;
  localparam logic [2:0] M_HALF = 3'd2;
  localparam logic [2:0] M_WORD = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic [2:0]  readMode;
  logic        unsignedLoad;
  logic [31:0] dataOutput;

  always #5 clk = ~clk;

  mem_access_sequencer_if cpu ();

  mem_access_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu),
    .address      (address),
    .data         (data),
    .writeMode    (writeMode),
    .readMode     (readMode),
    .unsignedLoad (unsignedLoad),
    .dataOutput   (dataOutput)
  );

  // Memory model: byte array, combinational read, write at the rising edge.
  logic [7:0] mem [logic [31:0]];
  int memVer = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } wr_t;
  wr_t wrLog[$];
  int  accessCount = 0;

  function automatic logic [7:0] rdByte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a, input logic [2:0] mode, input logic uns);
    logic [7:0]  b0;
    logic [15:0] h;
    b0 = rdByte(a);
    h  = {rdByte(a + 32'd1), b0};
    case (mode)
      M_BYTE:  return uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
      M_HALF:  return uns ? {16'd0, h} : {{16{h[15]}}, h};
      M_WORD:  return {rdByte(a + 32'd3), rdByte(a + 32'd2), h};
      default: return 32'd0;
    endcase
  endfunction

  always @(address or readMode or unsignedLoad or memVer)
    dataOutput = memRead(address, readMode, unsignedLoad);

  always @(posedge clk) begin
    if (writeMode != M_NONE || readMode != M_NONE) accessCount++;
    if (writeMode != M_NONE) begin
      wrLog.push_back('{address, data, writeMode});
      mem[address] = data[7:0];
      if (writeMode == M_HALF || writeMode == M_WORD) mem[address + 32'd1] = data[15:8];
      if (writeMode == M_WORD) begin
        mem[address + 32'd2] = data[23:16];
        mem[address + 32'd3] = data[31:24];
      end
      memVer++;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkWr(input string tag, input int idx, input logic [31:0] a,
                         input logic [2:0] mode, input logic [7:0] b);
    if (idx >= wrLog.size()) begin
      check({tag, " present"}, 32'd0, 32'd1);
    end else begin
      check({tag, " addr"}, wrLog[idx].addr, a);
      check({tag, " mode"}, {29'd0, wrLog[idx].mode}, {29'd0, mode});
      check({tag, " byte"}, {24'd0, wrLog[idx].data[7:0]}, {24'd0, b});
    end
  endtask

  // Push the expected response, drive one request, then pop and compare when rsp_valid appears.
  task automatic issue(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expRdata, input logic expErr, input int expLat);
    exp_t e;
    int   lat;
    sb.push_back('{tag, expRdata, expErr, expLat});
    wrLog.delete();
    accessCount = 0;
    @(negedge clk);
    cpu.req_valid    = 1'b1;
    cpu.req_write    = wr;
    cpu.req_size     = size;
    cpu.req_unsigned = uns;
    cpu.req_addr     = addr;
    cpu.req_wdata    = wdata;
    @(posedge clk);
    #1 cpu.req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " ready low"}, {31'd0, cpu.req_ready}, 32'd0);
      if (cpu.rsp_valid) lat = c;
    end
    e = sb.pop_front();
    check({e.tag, " latency"}, lat, e.lat);
    if (lat != 0) begin
      check({e.tag, " rdata"}, cpu.rsp_rdata, e.rdata);
      check({e.tag, " err"}, {31'd0, cpu.rsp_err}, {31'd0, e.err});
      @(negedge clk);
      check({e.tag, " one-cycle pulse"}, {31'd0, cpu.rsp_valid}, 32'd0);
      check({e.tag, " rdata held"}, cpu.rsp_rdata, e.rdata);
      check({e.tag, " idle modes"}, {26'd0, writeMode, readMode}, 32'd0);
      check({e.tag, " idle address"}, address, 32'd0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " req_ready"}, {31'd0, cpu.req_ready}, 32'd1);
    check({tag, " rsp_valid"}, {31'd0, cpu.rsp_valid}, 32'd0);
    check({tag, " rsp_err"}, {31'd0, cpu.rsp_err}, 32'd0);
    check({tag, " writeMode"}, {29'd0, writeMode}, {29'd0, M_NONE});
    check({tag, " readMode"}, {29'd0, readMode}, {29'd0, M_NONE});
    check({tag, " address"}, address, 32'd0);
    check({tag, " data"}, data, 32'd0);
    check({tag, " unsignedLoad"}, {31'd0, unsignedLoad}, 32'd0);
  endtask

  initial begin
    int sawValid;
    rst              = 1'b1;
    cpu.req_valid    = 1'b0;
    cpu.req_write    = 1'b0;
    cpu.req_size     = 2'd0;
    cpu.req_unsigned = 1'b0;
    cpu.req_addr     = 32'd0;
    cpu.req_wdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    check("reset rsp_rdata", cpu.rsp_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Aligned word store/load.
    issue("st word", 1'b1, 2'd2, 1'b0, 32'd65532, 32'h22345678, 32'd0, 1'b0, 2);
    checkWr("st word wr", 0, 32'd65532, M_WORD, 8'h78);
    check("st word data", wrLog.size() > 0 ? wrLog[0].data : 32'hX, 32'h22345678);
    issue("ld word", 1'b0, 2'd2, 1'b0, 32'd65532, 32'd0, 32'h22345678, 1'b0, 2);
    repeat (3) @(negedge clk);
    check("rdata hold idle", cpu.rsp_rdata, 32'h22345678);

    // Halfword signedness, byte signedness.
    issue("st half", 1'b1, 2'd1, 1'b0, 32'd65528, 32'h0000FFFF, 32'd0, 1'b0, 2);
    issue("ld half s", 1'b0, 2'd1, 1'b0, 32'd65528, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
    issue("ld half u", 1'b0, 2'd1, 1'b1, 32'd65528, 32'd0, 32'h0000FFFF, 1'b0, 2);
    issue("ld byte s", 1'b0, 2'd0, 1'b0, 32'd65528, 32'd0, 32'hFFFFFFFF, 1'b0, 2);
    issue("ld byte u", 1'b0, 2'd0, 1'b1, 32'd65528, 32'd0, 32'h000000FF, 1'b0, 2);
    issue("ld byte 0x34", 1'b0, 2'd0, 1'b0, 32'd65534, 32'd0, 32'h00000034, 1'b0, 2);

    // Illegal size: error, no memory access, rdata cleared.
    issue("size3", 1'b0, 2'd3, 1'b0, 32'd65532, 32'd0, 32'd0, 1'b1, 1);
    check("size3 no access", accessCount, 0);

`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    issue("st mis word", 1'b1, 2'd2, 1'b0, 32'd65529, 32'hA1B2C3D4, 32'd0, 1'b0, 5);
    check("st mis word count", wrLog.size(), 4);
    checkWr("st mis b0", 0, 32'd65529, M_BYTE, 8'hD4);
    checkWr("st mis b1", 1, 32'd65530, M_BYTE, 8'hC3);
    checkWr("st mis b2", 2, 32'd65531, M_BYTE, 8'hB2);
    checkWr("st mis b3", 3, 32'd65532, M_BYTE, 8'hA1);
    issue("ld mis word", 1'b0, 2'd2, 1'b0, 32'd65529, 32'd0, 32'hA1B2C3D4, 1'b0, 5);
    issue("ld mis half s", 1'b0, 2'd1, 1'b0, 32'd65529, 32'd0, 32'hFFFFC3D4, 1'b0, 3);
    issue("ld mis half u", 1'b0, 2'd1, 1'b1, 32'd65531, 32'd0, 32'h0000A1B2, 1'b0, 3);

    issue("st wrap", 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00009845, 32'd0, 1'b0, 3);
    checkWr("st wrap b0", 0, 32'hFFFFFFFF, M_BYTE, 8'h45);
    checkWr("st wrap b1", 1, 32'h00000000, M_BYTE, 8'h98);
    issue("ld wrap s", 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 32'hFFFF9845, 1'b0, 3);

    // Reset while the third byte of a split word store is on the bus.
    wrLog.delete();
    @(negedge clk);
    cpu.req_valid = 1'b1; cpu.req_write = 1'b1; cpu.req_size = 2'd2;
    cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h00001001; cpu.req_wdata = 32'h11223344;
    @(posedge clk);
    #1 cpu.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkIdleOutputs("mid-split reset");
    @(posedge clk);
    #1 rst = 1'b0;
    sawValid = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu.rsp_valid) sawValid++;
    end
    check("mid-split no rsp", sawValid, 0);
    check("mid-split writes", wrLog.size(), 2);
    check("mid-split byte0", {24'd0, rdByte(32'h1001)}, 32'h44);
    check("mid-split byte1", {24'd0, rdByte(32'h1002)}, 32'h33);
    check("mid-split byte2 absent", {31'd0, mem.exists(32'h1003)}, 32'd0);
`else
    issue("st mis word", 1'b1, 2'd2, 1'b0, 32'd65529, 32'hA1B2C3D4, 32'd0, 1'b1, 1);
    check("st mis no access", accessCount, 0);
    check("st mis no writes", wrLog.size(), 0);
    issue("ld mis half", 1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, 1);
    check("ld mis no access", accessCount, 0);

    // Reset while an aligned store is in ACCESS: nothing written, no response.
    wrLog.delete();
    @(negedge clk);
    cpu.req_valid = 1'b1; cpu.req_write = 1'b1; cpu.req_size = 2'd2;
    cpu.req_unsigned = 1'b0; cpu.req_addr = 32'h00001000; cpu.req_wdata = 32'h11223344;
    @(posedge clk);
    #1 cpu.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkIdleOutputs("mid-access reset");
    @(posedge clk);
    #1 rst = 1'b0;
    sawValid = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu.rsp_valid) sawValid++;
    end
    check("mid-access no rsp", sawValid, 0);
    check("mid-access no writes", wrLog.size(), 0);
`endif

    // Sequencer still works after reset.
    issue("post-reset ld", 1'b0, 2'd2, 1'b0, 32'd65532, 32'd0,
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
          32'h223456A1,
`else
          32'h22345678,
`endif
          1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
